// File: rtl/multiply_acc_reader.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multiply_acc_reader: captures multiply_acc burst sums, rescales, buffers them
// Revision: 1.0
// ---------------------------------------------------------------------------
module multiply_acc_reader #(
  parameter int IMG_WIDTH = 16,
  parameter int KER_WIDTH = 8,
  parameter int OUT_WIDTH = 16,
  parameter int LATENCY   = 3,
  parameter int DEPTH     = 4,
  localparam int RES_WIDTH = IMG_WIDTH + KER_WIDTH + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mac_val,
  input  logic signed [RES_WIDTH-1:0] mac_result,
  input  logic [4:0]                  cfg_shift,
  input  logic                        cfg_relu,
  output logic signed [OUT_WIDTH-1:0] out_data,
  output logic                        out_sat,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic                        overflow,
  output logic [7:0]                  drop_count,
  output logic                        busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = RES_WIDTH + 1;
  localparam logic signed [SW-1:0] c_max = SW'((64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1);
  localparam logic signed [SW-1:0] c_min = ~c_max;

  logic                 r_val_d;
  logic [LATENCY-1:0]   r_tok;
  logic                 w_end;
  logic                 w_tok_exit;

  assign w_end      = r_val_d & ~mac_val;
  assign w_tok_exit = r_tok[LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_val_d <= 1'b0;
    else     r_val_d <= mac_val;
  end

  generate
    if (LATENCY == 1) begin : g_tok_single
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tok <= '0;
        else     r_tok <= w_end;
      end
    end else begin : g_tok_chain
      always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tok <= '0;
        else     r_tok <= {r_tok[LATENCY-2:0], w_end};
      end
    end
  endgenerate

  // One extra bit of headroom keeps the rounding add from wrapping.
  logic signed [SW-1:0]        w_ext;
  logic signed [SW-1:0]        w_rnd;
  logic signed [SW-1:0]        w_sum;
  logic signed [SW-1:0]        w_shr;
  logic signed [OUT_WIDTH-1:0] w_val;
  logic                        w_sat;

  always_comb begin
    w_ext = {mac_result[RES_WIDTH-1], mac_result};
    w_rnd = '0;
    if (cfg_shift != 5'd0) w_rnd = SW'(1) << (cfg_shift - 5'd1);
    w_sum = w_ext + w_rnd;
    if (32'(cfg_shift) >= RES_WIDTH) w_shr = {SW{mac_result[RES_WIDTH-1]}};
    else                             w_shr = w_sum >>> cfg_shift;
    w_val = w_shr[OUT_WIDTH-1:0];
    w_sat = 1'b0;
    if (cfg_relu && w_shr[SW-1]) begin
      w_val = '0;
    end else if (w_shr > c_max) begin
      w_val = c_max[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end else if (w_shr < c_min) begin
      w_val = c_min[OUT_WIDTH-1:0];
      w_sat = 1'b1;
    end
  end

  logic                 r_res_vld;
  logic [OUT_WIDTH-1:0] r_res_data;
  logic                 r_res_sat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_vld  <= 1'b0;
      r_res_data <= '0;
      r_res_sat  <= 1'b0;
    end else begin
      r_res_vld <= w_tok_exit;
      if (w_tok_exit) begin
        r_res_data <= w_val;
        r_res_sat  <= w_sat;
      end
    end
  end

  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic [OUT_WIDTH-1:0] r_mem_data [DEPTH];
  logic [DEPTH-1:0]     r_mem_sat;
  logic                 r_ovf;
  logic [7:0]           r_drop;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_pop;
  logic                 w_push;
  logic                 w_drop;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop   = ~w_empty & out_ready;
  // A pop frees the head slot in the same cycle, so a full FIFO can still accept.
  assign w_push  = r_res_vld & (~w_full | w_pop);
  assign w_drop  = r_res_vld & w_full & ~w_pop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem_data[i] <= '0;
      r_mem_sat <= '0;
    end else if (w_push) begin
      r_mem_data[r_wr_ptr[AW-1:0]] <= r_res_data;
      r_mem_sat[r_wr_ptr[AW-1:0]]  <= r_res_sat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_ovf    <= 1'b0;
      r_drop   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_ovf <= w_drop;
      if (w_drop && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
    end
  end

  assign out_data   = r_mem_data[r_rd_ptr[AW-1:0]];
  assign out_sat    = r_mem_sat[r_rd_ptr[AW-1:0]];
  assign out_valid  = ~w_empty;
  assign overflow   = r_ovf;
  assign drop_count = r_drop;
  assign busy       = mac_val | r_val_d | (|r_tok);

endmodule
`default_nettype wire
